// File: rtl/psum_store_ctrl.sv
// Psum write-back controller: buffers PE-array output psums in a small skid FIFO
// and writes them to the psum GLB in the load controller's address order, with optional ReLU.
module psum_store_ctrl #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_store_start,
  input  logic              i_last_pass,
  input  logic [2:0]        i_layer_n,
  input  logic [4:0]        i_layer_e,
  input  logic [4:0]        i_layer_p,
  input  logic              i_psum_valid,
  input  logic [DATA_W-1:0] i_psum_data,
  output logic              o_psum_ready,
  input  logic              i_glb_busy,
  output logic              o_psum_glb_we,
  output logic [15:0]       o_psum_glb_wa,
  output logic [DATA_W-1:0] o_psum_glb_wd,
  output logic              o_store_done
);
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ACC_W  = 11;
  localparam int unsigned ADDR_W = 16;

  typedef enum logic [2:0] {IDLE, STORE_SEQ, UPDATE_BASE, UPDATE_BATCH, DONE} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [ACC_W-1:0]  acc_cnt;
  logic [4:0]        cnt_p, cnt_e, iter_cnt;
  logic [2:0]        batch_cnt;
  logic              relu;

  logic              fifo_full, fifo_empty, push, pop;
  logic              p_last, e_last, iter_last, batch_last, last_pop;
  logic [ACC_W-1:0]  words_per_iter;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] rd_data;

  assign fifo_full      = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_empty     = (fifo_cnt == '0);
  assign words_per_iter = ACC_W'(i_layer_e) * ACC_W'(i_layer_p);
  assign o_psum_ready   = (state == STORE_SEQ) && !fifo_full && (acc_cnt < words_per_iter);
  assign push           = i_psum_valid && o_psum_ready;
  assign pop            = (state == STORE_SEQ) && !fifo_empty && !i_glb_busy;

  assign p_last     = (cnt_p == 5'(i_layer_p - 5'd1));
  assign e_last     = (cnt_e == 5'(i_layer_e - 5'd1));
  assign iter_last  = (iter_cnt == 5'(i_layer_e - 5'd1));
  assign batch_last = (batch_cnt == 3'(i_layer_n - 3'd1));
  assign last_pop   = pop && p_last && e_last;

  assign rd_data = fifo_mem[rd_ptr];
  // Same map as the load side: p-major, then e, then the iteration column
  assign addr_c = ADDR_W'(cnt_p) * ADDR_W'(i_layer_e) * ADDR_W'(i_layer_e)
                + ADDR_W'(cnt_e) * ADDR_W'(i_layer_e)
                + ADDR_W'(iter_cnt);

  assign o_store_done = (state == DONE);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (i_store_start) state_nxt = STORE_SEQ;
      STORE_SEQ:    if (last_pop) state_nxt = UPDATE_BASE;
      UPDATE_BASE:  state_nxt = iter_last ? UPDATE_BATCH : IDLE;
      UPDATE_BATCH: state_nxt = batch_last ? DONE : IDLE;
      DONE:         state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  // FIFO storage (data needs no reset; occupancy is tracked separately)
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= i_psum_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Sequencing counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_cnt   <= '0;
      cnt_p     <= '0;
      cnt_e     <= '0;
      iter_cnt  <= '0;
      batch_cnt <= '0;
      relu      <= 1'b0;
    end else begin
      if ((state == IDLE) && i_store_start) begin
        acc_cnt <= '0;
        cnt_p   <= '0;
        cnt_e   <= '0;
        relu    <= i_last_pass;
      end else begin
        if (push) acc_cnt <= acc_cnt + ACC_W'(1);
        if (pop) begin
          if (p_last) begin
            cnt_p <= '0;
            cnt_e <= e_last ? '0 : cnt_e + 5'd1;
          end else begin
            cnt_p <= cnt_p + 5'd1;
          end
        end
      end
      if (state == UPDATE_BASE)  iter_cnt  <= iter_last ? '0 : iter_cnt + 5'd1;
      if (state == UPDATE_BATCH) batch_cnt <= batch_last ? '0 : batch_cnt + 3'd1;
    end
  end

  // Registered GLB write port; address/data hold when idle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_psum_glb_we <= 1'b0;
      o_psum_glb_wa <= '0;
      o_psum_glb_wd <= '0;
    end else begin
      o_psum_glb_we <= pop;
      if (pop) begin
        o_psum_glb_wa <= addr_c;
        o_psum_glb_wd <= (relu && rd_data[DATA_W-1]) ? '0 : rd_data;
      end
    end
  end

endmodule

// File: tb/tb_psum_store_ctrl.sv
// Randomized directed bench for psum_store_ctrl: expected GLB writes come from
// the address/ReLU rules applied to the words the bench handed over.
module tb_psum_store_ctrl;
  localparam int unsigned DATA_W = 16;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_store_start;
  logic              i_last_pass;
  logic [2:0]        i_layer_n;
  logic [4:0]        i_layer_e;
  logic [4:0]        i_layer_p;
  logic              i_psum_valid;
  logic [DATA_W-1:0] i_psum_data;
  logic              o_psum_ready;
  logic              i_glb_busy;
  logic              o_psum_glb_we;
  logic [15:0]       o_psum_glb_wa;
  logic [DATA_W-1:0] o_psum_glb_wd;
  logic              o_store_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [15:0]       wa_q[$];
  logic [DATA_W-1:0] wd_q[$];
  int                wc_q[$];
  logic [DATA_W-1:0] dat_q[$];
  int m_iter = 0;
  int m_batch = 0;
  int acc_at_busy = 0;
  logic rdy_at_busy = 1'b0;

  psum_store_ctrl #(.DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_store_start(i_store_start), .i_last_pass(i_last_pass),
    .i_layer_n(i_layer_n), .i_layer_e(i_layer_e), .i_layer_p(i_layer_p),
    .i_psum_valid(i_psum_valid), .i_psum_data(i_psum_data), .o_psum_ready(o_psum_ready),
    .i_glb_busy(i_glb_busy), .o_psum_glb_we(o_psum_glb_we), .o_psum_glb_wa(o_psum_glb_wa),
    .o_psum_glb_wd(o_psum_glb_wd), .o_store_done(o_store_done)
  );

  always #5 i_clk = ~i_clk;

  // Write/done monitor, sampled mid-cycle
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_psum_glb_we) begin
        wa_q.push_back(o_psum_glb_wa);
        wd_q.push_back(o_psum_glb_wd);
        wc_q.push_back(cyc);
      end
      if (o_store_done) done_cnt = done_cnt + 1;
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_store_start = 1'b0;
    i_psum_valid = 1'b0;
    i_glb_busy = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    m_iter = 0;
    m_batch = 0;
  endtask

  function automatic logic [DATA_W-1:0] next_word();
    if (dat_q.size() > 0) return dat_q.pop_front();
    return DATA_W'($urandom);
  endfunction

  // One iteration: start, offer nwords, expect E*P writes in load-controller order
  task automatic run_iter(input int e, input int p, input int n, input bit last, input int nwords,
                          input int busy_cycles, input bit gaps, input int mid_start);
    logic [DATA_W-1:0] acc_q[$];
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] exp_wd;
    int idx = 0;
    int ep = e * p;
    int extra = 0;
    int d0;
    bit exp_done;
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    d0 = done_cnt;
    i_layer_e = 5'(e); i_layer_p = 5'(p); i_layer_n = 3'(n);
    @(posedge i_clk); #1;
    i_store_start = 1'b1; i_last_pass = last;
    @(posedge i_clk); #1;
    i_store_start = 1'b0; i_last_pass = ~last;
    cur = next_word();
    for (int c = 0; c < busy_cycles + 4 * ep + 40; c++) begin
      i_glb_busy = (c < busy_cycles);
      i_store_start = (c == mid_start);
      i_psum_valid = (idx < nwords) && (!gaps || $urandom_range(0, 3) != 0);
      i_psum_data = cur;
      @(negedge i_clk);
      if (i_psum_valid && o_psum_ready) begin
        acc_q.push_back(cur);
        idx++;
        cur = next_word();
      end
      if (c == busy_cycles - 1) begin
        acc_at_busy = acc_q.size();
        rdy_at_busy = o_psum_ready;
      end
      if (wa_q.size() >= ep && c >= busy_cycles) extra++;
      @(posedge i_clk); #1;
      if (extra >= 6) break;
    end
    i_psum_valid = 1'b0; i_glb_busy = 1'b0; i_store_start = 1'b0;
    chk("accepted", acc_q.size(), (nwords < ep) ? nwords : ep);
    chk("writes", wa_q.size(), ep);
    for (int k = 0; k < ep && k < wa_q.size() && k < acc_q.size(); k++) begin
      exp_wd = (last && acc_q[k][DATA_W-1]) ? '0 : acc_q[k];
      chk($sformatf("wa[%0d]", k), wa_q[k], 16'(((k % p) * e * e) + ((k / p) * e) + m_iter));
      chk($sformatf("wd[%0d]", k), wd_q[k], exp_wd);
    end
    exp_done = (m_iter == e - 1) && (m_batch == n - 1);
    chk("done_pulses", done_cnt - d0, exp_done);
    if (m_iter == e - 1) begin
      m_iter = 0;
      m_batch = (m_batch + 1) % n;
    end else begin
      m_iter++;
    end
  endtask

  initial begin
    i_rst = 1'b1; i_store_start = 1'b0; i_last_pass = 1'b0;
    i_layer_n = 3'd1; i_layer_e = 5'd2; i_layer_p = 5'd2;
    i_psum_valid = 1'b0; i_psum_data = '0; i_glb_busy = 1'b0;

    // Reset values
    do_reset();
    @(negedge i_clk);
    chk("rst_ready", o_psum_ready, 0);
    chk("rst_we", o_psum_glb_we, 0);
    chk("rst_wa", o_psum_glb_wa, 0);
    chk("rst_wd", o_psum_glb_wd, 0);
    chk("rst_done", o_store_done, 0);

    // E=2 P=2 N=1, data 1..4 twice; done after the second iteration
    for (int i = 1; i <= 4; i++) dat_q.push_back(DATA_W'(i));
    run_iter(2, 2, 1, 1'b0, 4, 0, 1'b0, -1);
    for (int i = 1; i <= 4; i++) dat_q.push_back(DATA_W'(i));
    run_iter(2, 2, 1, 1'b0, 4, 0, 1'b0, -1);

    // ReLU on last pass, passthrough otherwise
    do_reset();
    dat_q.push_back(16'hFFF0); dat_q.push_back(16'h0005);
    run_iter(2, 1, 1, 1'b1, 2, 0, 1'b0, -1);
    chk("relu_neg", wd_q.size() > 0 ? wd_q[0] : 16'hDEAD, 16'h0000);
    dat_q.push_back(16'hFFF0); dat_q.push_back(16'h0005);
    run_iter(2, 1, 1, 1'b0, 2, 0, 1'b0, -1);
    chk("norelu_neg", wd_q.size() > 0 ? wd_q[0] : 16'hDEAD, 16'hFFF0);

    // GLB busy for 10 cycles: FIFO fills to 4, then drains back to back
    do_reset();
    run_iter(3, 2, 1, 1'b0, 6, 10, 1'b0, -1);
    chk("busy_accepted", acc_at_busy, 4);
    chk("busy_ready", rdy_at_busy, 0);
    for (int i = 0; i < 3 && wc_q.size() >= 4; i++)
      chk($sformatf("busy_consec%0d", i), wc_q[i+1] - wc_q[i], 1);

    // Extra 5th word rejected, stray start mid-iteration ignored; then random iterations
    do_reset();
    run_iter(2, 2, 2, 1'b0, 5, 0, 1'b1, 2);
    for (int i = 0; i < 3; i++)
      run_iter(2, 2, 2, 1'($urandom_range(0, 1)), 4, $urandom_range(0, 6), 1'b1, -1);

    // Reset with 3 words buffered: no writes afterwards, next iteration restarts at iter 0
    do_reset();
    run_iter(2, 2, 1, 1'b0, 4, 0, 1'b1, -1);
    @(posedge i_clk); #1 i_store_start = 1'b1;
    @(posedge i_clk); #1 i_store_start = 1'b0; i_glb_busy = 1'b1; i_psum_valid = 1'b1;
    repeat (3) begin
      i_psum_data = DATA_W'($urandom);
      @(posedge i_clk); #1;
    end
    i_psum_valid = 1'b0; i_glb_busy = 1'b0; i_rst = 1'b1;
    @(posedge i_clk); #1 i_rst = 1'b0;
    wa_q.delete();
    repeat (5) @(negedge i_clk);
    chk("rst_mid_nowrite", wa_q.size(), 0);
    chk("rst_mid_ready", o_psum_ready, 0);
    m_iter = 0; m_batch = 0;
    run_iter(2, 2, 1, 1'b0, 4, 0, 1'b1, -1);
    chk("rst_mid_first_wa", wa_q.size() > 0 ? wa_q[0] : 16'hDEAD, 16'h0000);

    // Largest address: E=P=31 at iter 30
    do_reset();
    for (int i = 0; i < 30; i++) run_iter(31, 1, 1, 1'b0, 31, 0, 1'b1, -1);
    run_iter(31, 31, 1, 1'b0, 961, 0, 1'b1, -1);
    chk("max_wa", wa_q.size() > 0 ? wa_q[wa_q.size()-1] : 16'hDEAD, 16'h745E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
